sd_cmd_engine: RTL and testbench
================================

SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: Clk cycles allowed between line release and response start bit.
REQ-002 SHALL have parameter NCC_CYCLES, default 8: idle cycles after a transaction before Ready reasserts.
REQ-003 SHALL have port Clk  in  1  clock, one SD bit per rising edge; the only clock.
REQ-004 SHALL have port ResetSync  in  1  synchronous, active-high reset.
REQ-005 SHALL have port CmdId  in  6  command index.
REQ-006 SHALL have port Arg  in  32  command argument.
REQ-007 SHALL have port RespType  in  2  00 none, 01 short 48-bit with CRC, 10 long 136-bit, 11 short without CRC (R3).
REQ-008 SHALL have port Valid  in  1  request; accepted when Valid and Ready are both high.
REQ-009 SHALL have port Ready  out  1  engine idle, able to accept a command.
REQ-010 SHALL have port CmdOut  out  1  serial data driven toward the card.
REQ-011 SHALL have port CmdOutEn  out  1  tri-state enable for CmdOut; external pad logic resolves the wire.
REQ-012 SHALL have port CmdIn  in  1  sampled CMD line.
REQ-013 SHALL have port Receiving  out  1  high while waiting for or shifting in a response.
REQ-014 SHALL have port Resp  out  136  captured response frame, right-aligned.
REQ-015 SHALL have port Done  out  1  one-cycle pulse at transaction end.
REQ-016 SHALL have port TimeoutErr  out  1  qualified by Done.
REQ-017 SHALL have port CrcErr  out  1  qualified by Done.

Function
REQ-018 SHALL implement states Idle, Send, Release, WaitStart, Recv, Ncc.
REQ-019 SHALL, on acceptance in cycle N, capture CmdId, Arg and RespType, and drive the start bit in cycle N+1.
REQ-020 SHALL send the 48-bit frame MSB-first in cycles N+1..N+48: 0, 1, CmdId[5:0], Arg[31:0], CRC7[6:0], 1.
REQ-021 SHALL compute CRC7 over the first 40 bits using polynomial x^7+x^3+1 with a zero seed, updated serially.
REQ-022 SHALL hold CmdOutEn high during cycles N+1..N+48 and low in all other cycles.
REQ-023 SHALL idle CmdOut at 1 whenever CmdOutEn is low.
REQ-024 SHALL, for RespType 00, go from Send to Ncc and pulse Done in cycle N+49 with both error flags low.
REQ-025 SHALL otherwise enter WaitStart with Receiving high and count cycles from 1.
REQ-026 SHALL, on the first CmdIn=0 in WaitStart, enter Recv; that start bit is Resp bit 0 of the frame.
REQ-027 SHALL, if TIMEOUT_CYCLES cycles pass without a start bit, pulse Done with TimeoutErr=1, leave Resp unchanged, and enter Ncc.
REQ-028 SHALL shift 48 bits total for short responses and 136 bits total for long responses, MSB-first, into Resp.
REQ-029 SHALL zero Resp[135:48] for short responses.
REQ-030 SHALL pulse Done in the cycle after the last bit is sampled; Receiving falls in the same cycle.
REQ-031 SHALL hold Resp, TimeoutErr and CrcErr stable from Done until the next acceptance.
REQ-032 SHALL keep Ready low for NCC_CYCLES cycles after Done and reassert it in the following cycle.
REQ-033 SHALL ignore Valid whenever Ready is low, with no queuing.
REQ-034 SHALL ignore CmdIn outside WaitStart and Recv.
REQ-035 SHALL hold Ready low in Send, Release, WaitStart, Recv and Ncc.

Reset
REQ-036 SHALL, while ResetSync is high at a Clk edge, enter Idle with Ready=1, CmdOutEn=0, CmdOut=1, Receiving=0, Done=0, TimeoutErr=0, CrcErr=0 and Resp=0.
REQ-037 SHALL abort any transfer in progress on reset without emitting Done.
REQ-038 SHALL release CmdOutEn in the reset cycle.

Configuration
REQ-039 SHALL, with SD_CMD_CRC_CHECK_EN defined, check the received CRC7 for RespType 01 over frame bits 47..8.
REQ-040 SHALL, with SD_CMD_CRC_CHECK_EN defined, check the received CRC7 for RespType 10 over frame bits 127..8.
REQ-041 SHALL, with SD_CMD_CRC_CHECK_EN defined, set CrcErr at Done when the received CRC7 mismatches or the end bit is 0.
REQ-042 SHALL, without SD_CMD_CRC_CHECK_EN, omit the receive CRC logic and tie CrcErr to 0.
REQ-043 SHALL never check CRC for RespType 11, with or without the macro.

Verification
REQ-044 SHALL cover: CMD0, Arg 0, RespType 00 -> CmdOut frame 0x40_00000000_95, Done at N+49, Ready high at N+58.
REQ-045 SHALL cover: CMD8, Arg 0x000001AA -> frame 0x48_000001AA_87, then card replies 0x08_000001AA_13 after 5 cycles -> Resp[47:0] matches, no errors.
REQ-046 SHALL cover: RespType 01 with CmdIn held at 1 -> Done exactly 64 cycles after release, TimeoutErr=1.
REQ-047 SHALL cover: a short response with the CRC byte corrupted to 0x15 -> CrcErr=1 when SD_CMD_CRC_CHECK_EN is defined, and 0 when it is not.
REQ-048 SHALL cover: RespType 10 with a 136-bit CSD pattern -> Resp[135:0] equals the sent bits and Done follows the last bit.
REQ-049 SHALL cover: ResetSync asserted at bit 20 of Send -> CmdOutEn=0 next cycle, no Done, and a new command accepted immediately.

Source files
------------

// File: rtl/sd_cmd_engine_if.sv
// sd_cmd_engine_if
//   Groups the host request handshake, the serial CMD line pins and the
//   response/status outputs of the SD command engine into one bundle.
//
//   Host request : CmdId[5:0], Arg[31:0], RespType[1:0], Valid -> engine
//                  Ready <- engine
//   CMD line     : CmdOut, CmdOutEn <- engine (pad logic resolves the wire)
//                  CmdIn -> engine (sampled CMD line)
//   Status       : Receiving, Resp[135:0], Done, TimeoutErr, CrcErr <- engine
//
//   modport slave  : the engine side
//   modport master : the host / pad side
interface sd_cmd_engine_if;
  logic [5:0]   CmdId;
  logic [31:0]  Arg;
  logic [1:0]   RespType;
  logic         Valid;
  logic         Ready;
  logic         CmdOut;
  logic         CmdOutEn;
  logic         CmdIn;
  logic         Receiving;
  logic [135:0] Resp;
  logic         Done;
  logic         TimeoutErr;
  logic         CrcErr;

  modport slave (
    input  CmdId, Arg, RespType, Valid, CmdIn,
    output Ready, CmdOut, CmdOutEn, Receiving, Resp, Done, TimeoutErr, CrcErr
  );

  modport master (
    output CmdId, Arg, RespType, Valid, CmdIn,
    input  Ready, CmdOut, CmdOutEn, Receiving, Resp, Done, TimeoutErr, CrcErr
  );
endinterface

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine
//   Serial SD CMD-line engine. Accepts one command (index, argument, response
//   type) on Valid&&Ready, shifts out the 48-bit command frame MSB-first with
//   its CRC7, then optionally waits for and captures a 48- or 136-bit
//   response. Done pulses for one cycle at the end of every transaction,
//   after which Ready stays low for NCC_CYCLES cycles.
//
//   Ports:
//     Clk        : clock, one SD bit per rising edge
//     ResetSync  : synchronous active-high reset
//     bus        : sd_cmd_engine_if.slave (request, CMD pins, response/status)
//
//   Parameters:
//     TIMEOUT_CYCLES : cycles allowed between line release and response start bit
//     NCC_CYCLES     : idle cycles after Done before Ready reasserts
//
//   Build option:
//     SD_CMD_CRC_CHECK_EN : when defined, the CRC7 and end bit of R1/R2-style
//                           responses are checked and reported on CrcErr;
//                           otherwise CrcErr is tied low.
//
//   Cycle map (acceptance in cycle N): Send drives frame bits 47..1 in
//   N+1..N+47, Release drives the end bit in N+48, and the line is let go at
//   the edge ending N+48.
module sd_cmd_engine #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NCC_CYCLES     = 8
) (
  input logic           Clk,
  input logic           ResetSync,
  sd_cmd_engine_if.slave bus
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NCC_W  = $clog2(NCC_CYCLES + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_FIRST = WAIT_W'(1);
  localparam logic [NCC_W-1:0]  NCC_LAST   = NCC_W'(NCC_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    RELEASE,
    WAIT_START,
    RECV,
    NCC
  } state_t;

  state_t             state_reg;
  logic               ready_reg;
  logic               cmd_out_reg;
  logic               cmd_out_en_reg;
  logic               receiving_reg;
  logic               done_reg;
  logic               timeout_err_reg;
  logic [135:0]       resp_reg;
  logic [1:0]         resp_type_reg;
  logic [38:0]        tx_shift_reg;   // frame bits 46..8, next bit in [38]
  logic [6:0]         tx_crc_reg;
  logic [5:0]         tx_idx_reg;     // index of the frame bit on the wire
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic [7:0]         rx_cnt_reg;     // number of response bits already sampled
  logic [NCC_W-1:0]   ncc_cnt_reg;
`ifdef SD_CMD_CRC_CHECK_EN
  logic [6:0]         rx_crc_reg;
  logic               crc_err_reg;
`endif

  // Serial CRC7 step, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  // Index of the final response bit: 136-bit frame for RespType 10, else 48.
  logic [7:0] rx_last;
  assign rx_last = (resp_type_reg == 2'b10) ? 8'd135 : 8'd47;

`ifdef SD_CMD_CRC_CHECK_EN
  // Long responses cover frame bits 127..8 (skip start/tx/reserved byte);
  // short responses cover frame bits 47..8.
  logic rx_crc_window;
  assign rx_crc_window = (resp_type_reg == 2'b10) ?
                         ((rx_cnt_reg >= 8'd8) && (rx_cnt_reg <= 8'd127)) :
                         (rx_cnt_reg <= 8'd39);
`endif

  always_ff @(posedge Clk) begin
    if (ResetSync) begin
      state_reg       <= IDLE;
      ready_reg       <= 1'b1;
      cmd_out_reg     <= 1'b1;
      cmd_out_en_reg  <= 1'b0;
      receiving_reg   <= 1'b0;
      done_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      resp_reg        <= '0;
      resp_type_reg   <= 2'b00;
      tx_shift_reg    <= '0;
      tx_crc_reg      <= '0;
      tx_idx_reg      <= '0;
      wait_cnt_reg    <= '0;
      rx_cnt_reg      <= '0;
      ncc_cnt_reg     <= '0;
`ifdef SD_CMD_CRC_CHECK_EN
      rx_crc_reg      <= '0;
      crc_err_reg     <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.Valid && ready_reg) begin
            resp_type_reg   <= bus.RespType;
            tx_shift_reg    <= {1'b1, bus.CmdId, bus.Arg};
            // Start bit (0) goes out now; with a zero seed it leaves CRC at 0.
            tx_crc_reg      <= '0;
            tx_idx_reg      <= '0;
            cmd_out_reg     <= 1'b0;
            cmd_out_en_reg  <= 1'b1;
            ready_reg       <= 1'b0;
            timeout_err_reg <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
            crc_err_reg     <= 1'b0;
`endif
            state_reg       <= SEND;
          end
        end

        SEND: begin
          tx_idx_reg <= tx_idx_reg + 6'd1;
          if (tx_idx_reg < 6'd39) begin
            // next bit is one of frame bits 46..8: payload, folded into CRC
            cmd_out_reg  <= tx_shift_reg[38];
            tx_crc_reg   <= crc7_step(tx_crc_reg, tx_shift_reg[38]);
            tx_shift_reg <= {tx_shift_reg[37:0], 1'b0};
          end else if (tx_idx_reg < 6'd46) begin
            // next bit is one of the seven CRC bits
            cmd_out_reg <= tx_crc_reg[6];
            tx_crc_reg  <= {tx_crc_reg[5:0], 1'b0};
          end else begin
            cmd_out_reg <= 1'b1;   // end bit
            state_reg   <= RELEASE;
          end
        end

        RELEASE: begin
          cmd_out_reg    <= 1'b1;
          cmd_out_en_reg <= 1'b0;
          if (resp_type_reg == 2'b00) begin
            done_reg    <= 1'b1;
            ncc_cnt_reg <= '0;
            state_reg   <= NCC;
          end else begin
            receiving_reg <= 1'b1;
            wait_cnt_reg  <= WAIT_FIRST;
            state_reg     <= WAIT_START;
          end
        end

        WAIT_START: begin
          if (!bus.CmdIn) begin
            // Start bit is a 0, so the cleared register already holds it in bit 0.
            resp_reg   <= '0;
            rx_cnt_reg <= 8'd1;
`ifdef SD_CMD_CRC_CHECK_EN
            rx_crc_reg <= '0;
`endif
            state_reg  <= RECV;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            done_reg        <= 1'b1;
            timeout_err_reg <= 1'b1;
            receiving_reg   <= 1'b0;
            ncc_cnt_reg     <= '0;
            state_reg       <= NCC;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end

        RECV: begin
          resp_reg   <= {resp_reg[134:0], bus.CmdIn};
          rx_cnt_reg <= rx_cnt_reg + 8'd1;
`ifdef SD_CMD_CRC_CHECK_EN
          if (rx_crc_window) begin
            rx_crc_reg <= crc7_step(rx_crc_reg, bus.CmdIn);
          end
`endif
          if (rx_cnt_reg == rx_last) begin
            done_reg      <= 1'b1;
            receiving_reg <= 1'b0;
            ncc_cnt_reg   <= '0;
            state_reg     <= NCC;
`ifdef SD_CMD_CRC_CHECK_EN
            // resp_reg[6:0] holds the received CRC, CmdIn is the end bit.
            crc_err_reg <= (resp_type_reg != 2'b11) &&
                           ((resp_reg[6:0] != rx_crc_reg) || !bus.CmdIn);
`endif
          end
        end

        NCC: begin
          // Entered in the Done cycle; stays NCC_CYCLES more cycles.
          if (ncc_cnt_reg == NCC_LAST) begin
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end else begin
            ncc_cnt_reg <= ncc_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.Ready      = ready_reg;
  assign bus.CmdOut     = cmd_out_reg;
  assign bus.CmdOutEn   = cmd_out_en_reg;
  assign bus.Receiving  = receiving_reg;
  assign bus.Resp       = resp_reg;
  assign bus.Done       = done_reg;
  assign bus.TimeoutErr = timeout_err_reg;
`ifdef SD_CMD_CRC_CHECK_EN
  assign bus.CrcErr     = crc_err_reg;
`else
  assign bus.CrcErr     = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb_sd_cmd_engine
//   Directed self-checking bench for sd_cmd_engine. Inputs are driven and
//   outputs sampled on the falling edge; the DUT acts on the rising edge.
//   Expected frames and CRC bytes are hand-computed constants.
module tb_sd_cmd_engine;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int NCC_CYCLES     = 8;
`ifdef SD_CMD_CRC_CHECK_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  localparam logic [47:0]  CMD0_FRAME  = 48'h40_00000000_95;
  localparam logic [47:0]  CMD8_FRAME  = 48'h48_000001AA_87;
  localparam logic [135:0] R7_GOOD     = 136'h08_000001AA_13;
  localparam logic [135:0] R7_BADCRC   = 136'h08_000001AA_15;
  localparam logic [135:0] R3_FRAME    = 136'h3F_00FF8000_FF;
  // CSD-style long frame; CRC7 over bits 127..8 is 0x78 -> byte 0xF1.
  localparam logic [135:0] R2_FRAME    = 136'h3F_F000000000_0000000000_48000001AA_F1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  sd_cmd_engine_if bus();

  sd_cmd_engine #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .NCC_CYCLES(NCC_CYCLES)
  ) dut (
    .Clk(clk),
    .ResetSync(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  // Called on a falling edge in cycle N; returns on the falling edge of N+1.
  task automatic issue(input logic [5:0] id, input logic [31:0] arg, input logic [1:0] rt);
    checks++;
    if (bus.Ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: Ready=%b required 1", bus.Ready);
    end
    bus.CmdId = id;
    bus.Arg = arg;
    bus.RespType = rt;
    bus.Valid = 1'b1;
    @(negedge clk);
    bus.Valid = 1'b0;
  endtask

  // Samples cycles N+1..N+48; returns on the falling edge of N+49.
  task automatic capture_frame(output logic [47:0] frame, output int bad);
    bad = 0;
    for (int i = 47; i >= 0; i--) begin
      frame[i] = bus.CmdOut;
      if (bus.CmdOutEn !== 1'b1 || bus.Done !== 1'b0 || bus.Ready !== 1'b0) bad++;
      @(negedge clk);
    end
  endtask

  // Drives nbits response bits MSB-first, one per cycle; returns in the cycle
  // after the last bit is sampled (the expected Done cycle).
  task automatic drive_resp(input logic [135:0] frame, input int nbits, output int bad);
    bad = 0;
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.CmdIn = frame[i];
      if (bus.Done !== 1'b0 || bus.Receiving !== 1'b1) bad++;
      @(negedge clk);
    end
    bus.CmdIn = 1'b1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.Ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.Ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: Ready=%b after %0d cycles, required 1", bus.Ready, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.Ready !== 1'b1 || bus.CmdOutEn !== 1'b0 || bus.CmdOut !== 1'b1 ||
        bus.Receiving !== 1'b0 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: Ready=%b En=%b Out=%b Rx=%b Done=%b required 1 0 1 0 0",
               bus.Ready, bus.CmdOutEn, bus.CmdOut, bus.Receiving, bus.Done);
    end
    checks++;
    if (bus.TimeoutErr !== 1'b0 || bus.CrcErr !== 1'b0 || bus.Resp !== 136'd0) begin
      errors++;
      $display("FAIL reset_status: To=%b Crc=%b Resp=%h required 0 0 0",
               bus.TimeoutErr, bus.CrcErr, bus.Resp);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("txn reset: done");
  endtask

  task automatic test_cmd0();
    logic [47:0] frame;
    int bad;
    wait_ready();
    issue(6'd0, 32'h0, 2'b00);
    capture_frame(frame, bad);
    checks++;
    if (frame !== CMD0_FRAME) begin
      errors++;
      $display("FAIL cmd0_frame: got %h required %h", frame, CMD0_FRAME);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL cmd0_send_window: %0d bad cycles, required 0", bad);
    end
    // N+49
    checks++;
    if (bus.Done !== 1'b1 || bus.TimeoutErr !== 1'b0 || bus.CrcErr !== 1'b0 ||
        bus.CmdOutEn !== 1'b0 || bus.CmdOut !== 1'b1 || bus.Receiving !== 1'b0 ||
        bus.Ready !== 1'b0) begin
      errors++;
      $display("FAIL cmd0_done: Done=%b To=%b Crc=%b En=%b Out=%b Rx=%b Rdy=%b required 1 0 0 0 1 0 0",
               bus.Done, bus.TimeoutErr, bus.CrcErr, bus.CmdOutEn, bus.CmdOut,
               bus.Receiving, bus.Ready);
    end
    // Valid while Ready is low must be ignored
    bus.CmdId = 6'd55;
    bus.RespType = 2'b01;
    bus.Valid = 1'b1;
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.Ready !== 1'b0 || bus.CmdOutEn !== 1'b0 || bus.Done !== 1'b0) bad++;
    end
    bus.Valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL cmd0_ncc: %0d bad cycles in N+50..N+57, required 0", bad);
    end
    @(negedge clk);  // N+58
    checks++;
    if (bus.Ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd0_ready_n58: Ready=%b required 1", bus.Ready);
    end
    @(negedge clk);
    checks++;
    if (bus.CmdOutEn !== 1'b0 || bus.Ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd0_no_queue: En=%b Ready=%b required 0 1", bus.CmdOutEn, bus.Ready);
    end
    $display("txn cmd0: frame=%h", frame);
  endtask

  task automatic test_cmd8();
    logic [47:0] frame;
    int bad;
    wait_ready();
    issue(6'd8, 32'h000001AA, 2'b01);
    capture_frame(frame, bad);
    checks++;
    if (frame !== CMD8_FRAME || bad != 0) begin
      errors++;
      $display("FAIL cmd8_frame: got %h bad=%0d required %h bad=0", frame, bad, CMD8_FRAME);
    end
    checks++;
    if (bus.Receiving !== 1'b1 || bus.CmdOutEn !== 1'b0 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL cmd8_release: Rx=%b En=%b Done=%b required 1 0 0",
               bus.Receiving, bus.CmdOutEn, bus.Done);
    end
    repeat (5) @(negedge clk);
    drive_resp(R7_GOOD, 48, bad);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL cmd8_recv_window: %0d bad cycles, required 0", bad);
    end
    checks++;
    if (bus.Done !== 1'b1 || bus.Receiving !== 1'b0 || bus.Resp !== R7_GOOD ||
        bus.TimeoutErr !== 1'b0 || bus.CrcErr !== 1'b0) begin
      errors++;
      $display("FAIL cmd8_resp: Done=%b Rx=%b Resp=%h To=%b Crc=%b required 1 0 %h 0 0",
               bus.Done, bus.Receiving, bus.Resp, bus.TimeoutErr, bus.CrcErr, R7_GOOD);
    end
    @(negedge clk);
    checks++;
    if (bus.Done !== 1'b0 || bus.Resp !== R7_GOOD) begin
      errors++;
      $display("FAIL cmd8_hold: Done=%b Resp=%h required 0 %h", bus.Done, bus.Resp, R7_GOOD);
    end
    $display("txn cmd8: frame=%h resp=%h", frame, bus.Resp);
  endtask

  task automatic test_timeout();
    logic [47:0] frame;
    int bad;
    int c;
    wait_ready();
    issue(6'd2, 32'h0, 2'b01);
    capture_frame(frame, bad);
    c = 0;
    while (bus.Done !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c != TIMEOUT_CYCLES) begin
      errors++;
      $display("FAIL timeout_cycles: Done after %0d cycles, required %0d", c, TIMEOUT_CYCLES);
    end
    checks++;
    if (bus.TimeoutErr !== 1'b1 || bus.CrcErr !== 1'b0 || bus.Receiving !== 1'b0 ||
        bus.Resp !== R7_GOOD) begin
      errors++;
      $display("FAIL timeout_status: To=%b Crc=%b Rx=%b Resp=%h required 1 0 0 %h",
               bus.TimeoutErr, bus.CrcErr, bus.Receiving, bus.Resp, R7_GOOD);
    end
    @(negedge clk);
    checks++;
    if (bus.TimeoutErr !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold: To=%b required 1", bus.TimeoutErr);
    end
    $display("txn timeout: cycles=%0d", c);
  endtask

  task automatic test_crc_bad();
    logic [47:0] frame;
    int bad;
    wait_ready();
    issue(6'd8, 32'h000001AA, 2'b01);
    capture_frame(frame, bad);
    repeat (3) @(negedge clk);
    drive_resp(R7_BADCRC, 48, bad);
    checks++;
    if (bus.Done !== 1'b1 || bus.Resp !== R7_BADCRC || bus.CrcErr !== CRC_ON ||
        bus.TimeoutErr !== 1'b0 || bad != 0) begin
      errors++;
      $display("FAIL crc_bad: Done=%b Resp=%h Crc=%b To=%b bad=%0d required 1 %h %b 0 0",
               bus.Done, bus.Resp, bus.CrcErr, bus.TimeoutErr, bad, R7_BADCRC, CRC_ON);
    end
    @(negedge clk);
    checks++;
    if (bus.CrcErr !== CRC_ON) begin
      errors++;
      $display("FAIL crc_bad_hold: Crc=%b required %b", bus.CrcErr, CRC_ON);
    end
    $display("txn crc_bad: resp=%h crcerr=%b", bus.Resp, bus.CrcErr);
  endtask

  task automatic test_r3();
    logic [47:0] frame;
    int bad;
    wait_ready();
    issue(6'd41, 32'h40FF8000, 2'b11);
    capture_frame(frame, bad);
    repeat (2) @(negedge clk);
    drive_resp(R3_FRAME, 48, bad);
    checks++;
    if (bus.Done !== 1'b1 || bus.Resp !== R3_FRAME || bus.CrcErr !== 1'b0 || bad != 0) begin
      errors++;
      $display("FAIL r3_resp: Done=%b Resp=%h Crc=%b bad=%0d required 1 %h 0 0",
               bus.Done, bus.Resp, bus.CrcErr, bad, R3_FRAME);
    end
    $display("txn r3: resp=%h", bus.Resp);
  endtask

  task automatic test_long();
    logic [47:0] frame;
    int bad;
    wait_ready();
    issue(6'd9, 32'h00010000, 2'b10);
    capture_frame(frame, bad);
    repeat (2) @(negedge clk);
    drive_resp(R2_FRAME, 136, bad);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL long_window: %0d bad cycles (early Done or Receiving low), required 0", bad);
    end
    checks++;
    if (bus.Done !== 1'b1 || bus.Receiving !== 1'b0 || bus.Resp !== R2_FRAME ||
        bus.CrcErr !== 1'b0 || bus.TimeoutErr !== 1'b0) begin
      errors++;
      $display("FAIL long_resp: Done=%b Rx=%b Resp=%h Crc=%b To=%b required 1 0 %h 0 0",
               bus.Done, bus.Receiving, bus.Resp, bus.CrcErr, bus.TimeoutErr, R2_FRAME);
    end
    $display("txn long: resp=%h", bus.Resp);
  endtask

  task automatic test_reset_mid_send();
    logic [47:0] frame;
    int bad;
    wait_ready();
    issue(6'd17, 32'h00001000, 2'b01);
    repeat (20) @(negedge clk);   // bit 20 on the wire
    checks++;
    if (bus.CmdOutEn !== 1'b1) begin
      errors++;
      $display("FAIL midsend_active: En=%b required 1", bus.CmdOutEn);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.CmdOutEn !== 1'b0 || bus.CmdOut !== 1'b1 || bus.Done !== 1'b0 ||
        bus.Ready !== 1'b1 || bus.Receiving !== 1'b0 || bus.Resp !== 136'd0) begin
      errors++;
      $display("FAIL midsend_reset: En=%b Out=%b Done=%b Rdy=%b Rx=%b Resp=%h required 0 1 0 1 0 0",
               bus.CmdOutEn, bus.CmdOut, bus.Done, bus.Ready, bus.Receiving, bus.Resp);
    end
    rst = 1'b0;
    issue(6'd0, 32'h0, 2'b00);
    capture_frame(frame, bad);
    checks++;
    if (frame !== CMD0_FRAME || bad != 0 || bus.Done !== 1'b1) begin
      errors++;
      $display("FAIL midsend_new_cmd: frame=%h bad=%0d Done=%b required %h 0 1",
               frame, bad, bus.Done, CMD0_FRAME);
    end
    $display("txn reset_mid_send: new frame=%h", frame);
    wait_ready();
  endtask

  initial begin
    rst = 1'b1;
    bus.CmdId = 6'd0;
    bus.Arg = 32'd0;
    bus.RespType = 2'b00;
    bus.Valid = 1'b0;
    bus.CmdIn = 1'b1;
    @(negedge clk);
    test_reset();
    test_cmd0();
    test_cmd8();
    test_timeout();
    test_crc_bad();
    test_r3();
    test_long();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
